uart_pixel_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_byte.sv | 110 +++++++++++
 rtl/uart_pixel_rx.sv | 112 +++++++++++
 tb/tb_uart_pixel_rx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the host-to-FPGA pixel link receiver.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Rounded clock cycles per oversample tick.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int den;
        den = baud * oversample;
        return (clk_freq + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: rx synchroniser, free-running oversample tick, framing FSM.
// byte_valid / stop_err are single-cycle strobes issued in the stop-bit sample cycle.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       stop_err,
    output rx_state_t  state_dbg
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW  = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [PW-1:0] PH_HALF = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);

    logic          rx_meta, rx_sync;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    rx_state_t     state, state_n;
    logic [PW-1:0] phase, phase_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;

    assign tick      = (tick_cnt == TW'(DIV - 1));
    assign byte_data = shift;
    assign state_dbg = state;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            tick_cnt <= '0;
            state    <= IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            state    <= state_n;
            phase    <= phase_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
        end
    end

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    phase_n   = '0;
                    bit_cnt_n = '0;
                    state_n   = START;
                end
            end
            START: begin
                // Mid-start resample rejects short low glitches.
                if (tick) begin
                    if (phase == PH_HALF) begin
                        phase_n = '0;
                        state_n = rx_sync ? IDLE : DATA;
                    end else begin
                        phase_n = phase + PW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (phase == PH_LAST) begin
                        phase_n   = '0;
                        shift_n   = {rx_sync, shift[7:1]};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_n = STOP;
                    end else begin
                        phase_n = phase + PW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (phase == PH_LAST) begin
                        state_n    = IDLE;
                        byte_valid = rx_sync;
                        stop_err   = !rx_sync;
                    end else begin
                        phase_n = phase + PW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_pixel_rx.sv
// Pixel link receiver: assembles three UART bytes (R,G,B) into a 24-bit pixel register.
// Optional idle timeout on partial pixels is enabled by defining UART_PIXEL_TIMEOUT_EN.
module uart_pixel_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int OVERSAMPLE   = 16,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic        frame_err,
    output logic        overrun
);

    // Handshake: a pixel transfers on any posedge with pixel_valid && pixel_ready;
    // pixel_data is held stable while pixel_valid is high and pixel_ready is low.

    logic [7:0] byte_data;
    logic       byte_valid, stop_err;
    rx_state_t  rx_state;
    logic [1:0] idx;
    logic [7:0] part_r, part_g;
    rgb_t       next_pix;
    logic       timeout;

    uart_rx_byte #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_rx_byte (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .rx        (rx),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .stop_err  (stop_err),
        .state_dbg (rx_state)
    );

    assign next_pix = {part_r, part_g, byte_data};

`ifdef UART_PIXEL_TIMEOUT_EN
    localparam int TO_CYCLES = TIMEOUT_BITS * calc_div(CLK_FREQ, BAUD, OVERSAMPLE) * OVERSAMPLE;

    logic [31:0] idle_cnt;

    assign timeout = (rx_state == IDLE) && (idx != 2'd0) && (idle_cnt == 32'(TO_CYCLES - 1));

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (rx_state != IDLE || idx == 2'd0 || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign unused_cfg = ^{TIMEOUT_BITS, rx_state};
`endif

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            idx         <= 2'd0;
            part_r      <= '0;
            part_g      <= '0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (pixel_valid && pixel_ready) pixel_valid <= 1'b0;
            if (stop_err || timeout) begin
                // Drop back to a pixel boundary so the next byte is treated as R.
                idx       <= 2'd0;
                frame_err <= 1'b1;
            end else if (byte_valid) begin
                case (idx)
                    2'd0: begin
                        part_r <= byte_data;
                        idx    <= 2'd1;
                    end
                    2'd1: begin
                        part_g <= byte_data;
                        idx    <= 2'd2;
                    end
                    default: begin
                        idx <= 2'd0;
                        if (!pixel_valid || pixel_ready) begin
                            pixel_data  <= next_pix;
                            pixel_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_pixel_rx.sv
// Self-checking bench for uart_pixel_rx: directed vector table, hand-written corner sequences
// and randomized bytes checked against a byte-list pixel model.
module tb_uart_pixel_rx;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 781_250;
    localparam int OS       = 16;
    localparam int TO_BITS  = 32;
    localparam int BIT      = 64;   // 50 MHz / 781250 baud: 4 cycles per tick, 16 ticks per bit

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [23:0] exp;
    } vec_t;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        pixel_ready = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        frame_err;
    logic        overrun;

    int n_vec = 0, n_fail = 0;
    int n_hs = 0, valid_cycles = 0, ferr_cnt = 0, ovr_cnt = 0;
    int exp_ferr = 0, exp_ovr = 0;
    logic [23:0] exp_q[$];

    // Reference model state: bytes collected toward the current pixel.
    int         m_idx = 0;
    logic [7:0] m_buf[3];
    bit         m_hold = 1'b0;
    bit         m_full = 1'b0;

    vec_t vecs[4];

    uart_pixel_rx #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .OVERSAMPLE  (OS),
        .TIMEOUT_BITS(TO_BITS)
    ) dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .rx         (rx),
        .pixel_data (pixel_data),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #10 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge pclk) begin
        if (rst_n) begin
            if (pixel_valid) valid_cycles++;
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (pixel_valid && pixel_ready) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got %06h, expected no pixel", pixel_data);
                end else begin
                    check("pixel", {8'h0, pixel_data}, {8'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(BIT);
        end
        if (stop_ok) begin
            rx = 1'b1;
            cyc(BIT);
        end else begin
            // Low long enough to cover the stop sample, then a clean idle line.
            rx = 1'b0;
            cyc(40);
            rx = 1'b1;
            cyc(2 * BIT - 40);
        end
        cyc(BIT / 4);
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            exp_ferr++;
            m_idx = 0;
        end else begin
            m_buf[m_idx] = b;
            m_idx++;
            if (m_idx == 3) begin
                m_idx = 0;
                if (m_full) begin
                    exp_ovr++;
                end else begin
                    exp_q.push_back({m_buf[0], m_buf[1], m_buf[2]});
                    if (m_hold) m_full = 1'b1;
                end
            end
        end
    endtask

    task automatic send_model(input logic [7:0] b, input bit stop_ok);
        model_byte(b, stop_ok);
        send_byte(b, stop_ok);
    endtask

    task automatic set_ready(input logic v);
        pixel_ready = v;
        m_hold = !v;
        if (v) m_full = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            cyc(1);
            t++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #(90_000 * 20);
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, h0, f0;
        logic [7:0] rb;
        logic [7:0] pb;

        vecs[0] = '{8'h12, 8'h34, 8'h56, 24'h123456};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 24'h000000};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF};
        vecs[3] = '{8'hA5, 8'h5A, 8'hC3, 24'hA55AC3};

        pixel_ready = 1'b1;
        #5;
        check("reset_pixel_valid", pixel_valid, 0);
        check("reset_pixel_data", pixel_data, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        cyc(5);
        rst_n = 1'b1;
        cyc(5);

        // Directed vectors, consumer always ready: one single-cycle pixel each.
        foreach (vecs[i]) begin
            v0 = valid_cycles;
            exp_q.push_back(vecs[i].exp);
            send_byte(vecs[i].b0, 1'b1);
            send_byte(vecs[i].b1, 1'b1);
            send_byte(vecs[i].b2, 1'b1);
            wait_drain(BIT);
            check("valid_one_cycle", valid_cycles - v0, 1);
        end
        check("table_frame_err", ferr_cnt, 0);
        check("table_overrun", ovr_cnt, 0);

        // Overrun: second pixel completes while the first is still held.
        set_ready(1'b0);
        send_model(8'hFF, 1'b1);
        send_model(8'h00, 1'b1);
        send_model(8'h00, 1'b1);
        check("held_valid", pixel_valid, 1);
        check("held_data", pixel_data, 24'hFF0000);
        send_model(8'h00, 1'b1);
        send_model(8'hFF, 1'b1);
        send_model(8'h00, 1'b1);
        check("overrun_pulses", ovr_cnt, 1);
        check("held_data_after_overrun", pixel_data, 24'hFF0000);
        h0 = n_hs;
        set_ready(1'b1);
        cyc(3);
        check("one_handshake", n_hs - h0, 1);
        check("valid_cleared", pixel_valid, 0);
        wait_drain(BIT);

        // Bad stop bit discards the byte and resyncs.
        f0 = ferr_cnt;
        send_model(8'hAA, 1'b0);
        send_model(8'h01, 1'b1);
        send_model(8'h02, 1'b1);
        send_model(8'h03, 1'b1);
        wait_drain(BIT);
        check("bad_stop_frame_err", ferr_cnt - f0, 1);

        // Short low glitch on an idle line captures nothing.
        rx = 1'b0;
        cyc(16);
        rx = 1'b1;
        cyc(2 * BIT);
        send_model(8'hAB, 1'b1);
        send_model(8'hCD, 1'b1);
        send_model(8'hEF, 1'b1);
        wait_drain(BIT);
        check("glitch_frame_err", ferr_cnt, exp_ferr);

        // Reset in the middle of DATA bit 4 of the second byte, with a pixel held.
        set_ready(1'b0);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h5B, 1'b1);
        send_byte(8'h5C, 1'b1);
        check("pre_reset_valid", pixel_valid, 1);
        check("pre_reset_data", pixel_data, 24'h5A5B5C);
        send_byte(8'h99, 1'b1);
        pb = 8'h77;
        rx = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = pb[i];
            cyc(BIT);
        end
        rx = pb[4];
        cyc(BIT / 2);
        rst_n = 1'b0;
        #2;
        check("midreset_pixel_valid", pixel_valid, 0);
        check("midreset_pixel_data", pixel_data, 0);
        check("midreset_frame_err", frame_err, 0);
        check("midreset_overrun", overrun, 0);
        cyc(3);
        rx = 1'b1;
        cyc(2 * BIT);
        rst_n = 1'b1;
        m_idx = 0;
        set_ready(1'b1);
        cyc(4);
        send_model(8'h11, 1'b1);
        send_model(8'h22, 1'b1);
        send_model(8'h33, 1'b1);
        wait_drain(BIT);

        // Randomized bytes with occasional framing errors.
        for (int i = 0; i < 20; i++) begin
            rb = 8'($urandom_range(0, 255));
            send_model(rb, $urandom_range(0, 7) != 0);
        end
        while (m_idx != 0) send_model(8'($urandom_range(0, 255)), 1'b1);
        wait_drain(BIT);
        check("random_frame_err", ferr_cnt, exp_ferr);
        check("random_overrun", ovr_cnt, exp_ovr);

        // Partial pixel followed by a long idle line.
        send_model(8'h77, 1'b1);
        send_model(8'h88, 1'b1);
        cyc(33 * BIT);
`ifdef UART_PIXEL_TIMEOUT_EN
        m_idx = 0;
        exp_ferr++;
`endif
        send_model(8'h01, 1'b1);
        send_model(8'h02, 1'b1);
        send_model(8'h03, 1'b1);
        wait_drain(BIT);
        check("idle_frame_err", ferr_cnt, exp_ferr);
        check("final_overrun", ovr_cnt, exp_ovr);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
